// File: rtl/lru_req_queue4_pkg.sv
// Shared definitions for the four-requester LRU arbiter slice: requester count,
// ID width and grant-vector helpers used by the queue stage and arbiter benches.
package lru_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    // True when exactly one bit of the grant vector is set.
    function automatic logic is_onehot4(input logic [NUM_REQ-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Index of the set bit; callers qualify with is_onehot4 first.
    function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lru_req_queue4_req_fifo.sv
// Single requester FIFO: circular buffer with a write-through-when-popping rule,
// so a full FIFO still accepts a push in the cycle it is popped.
module req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;
    logic              accept;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign rdata  = mem[rd_ptr];
    assign do_pop = pop && !empty;
    // A pop this cycle frees the slot the push is about to use.
    assign accept = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !accept) begin
                count <= count - CNT_W'(1);
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/lru_req_queue4.sv
// Request buffering stage in front of arbiter_LRU4: four client FIFOs feed
// req_vector, and the returned grant pops one FIFO into a registered output.
module lru_req_queue4
    import lru_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        push,
    input  logic [NUM_REQ*DATA_W-1:0] push_data,
    output logic [NUM_REQ-1:0]        full,
    output logic [NUM_REQ-1:0]        req_vector,
    input  logic [NUM_REQ-1:0]        grant_vector,
    output logic                      out_valid,
    output logic [ID_W-1:0]           out_id,
    output logic [DATA_W-1:0]         out_data,
    output logic [NUM_REQ-1:0]        overflow,
    output logic                      grant_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] empty;
    logic [DATA_W-1:0]  rdata [NUM_REQ];
    logic [CNT_W-1:0]   count [NUM_REQ];
    logic               grant_ok;
    logic               grant_bad;
    logic [ID_W-1:0]    pop_id;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        req_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[g]),
            .pop      (pop[g]),
            .wdata    (push_data[g*DATA_W +: DATA_W]),
            .rdata    (rdata[g]),
            .count    (count[g]),
            .empty    (empty[g]),
            .full     (full[g]),
            .overflow (overflow[g])
        );
        assign req_vector[g] = (count[g] != '0);
    end

    // Grant is ignored entirely while enable is low; a multi-bit grant pops nothing.
    always_comb begin
        grant_ok  = is_onehot4(grant_vector);
        pop       = (enable && grant_ok) ? (grant_vector & ~empty) : '0;
        grant_bad = enable && (grant_vector != '0) &&
                    (!grant_ok || ((grant_vector & empty) != '0));
        pop_id    = onehot_to_idx(grant_vector);
    end

    // out_valid is a one-cycle strobe with no back-pressure: it is high exactly
    // in the cycle after a pop, and out_id/out_data hold between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
            grant_err <= 1'b0;
        end else begin
            out_valid <= (pop != '0);
            if (pop != '0) begin
                out_id   <= pop_id;
                out_data <= rdata[pop_id];
            end
            if (grant_bad) begin
                grant_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lru_req_queue4.sv
// Randomised and directed bench for lru_req_queue4 against a queue-based
// reference model; popped payloads are checked through an expected queue.
module tb_lru_req_queue4;
    import lru_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int W     = ID_W + DW;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [3:0]          push;
    logic [4*DW-1:0]     push_data;
    logic [3:0]          grant_vector;
    logic [3:0]          full;
    logic [3:0]          req_vector;
    logic                out_valid;
    logic [ID_W-1:0]     out_id;
    logic [DW-1:0]       out_data;
    logic [3:0]          overflow;
    logic                grant_err;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [DW-1:0] mq [4][$];
    logic [W-1:0]  exp_q [$];
    logic          exp_valid = 1'b0;
    logic [3:0]    m_ov = '0;
    logic          m_gerr = 1'b0;
    bit            mon_en = 1'b0;

    lru_req_queue4 #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .push         (push),
        .push_data    (push_data),
        .full         (full),
        .req_vector   (req_vector),
        .grant_vector (grant_vector),
        .out_valid    (out_valid),
        .out_id       (out_id),
        .out_data     (out_data),
        .overflow     (overflow),
        .grant_err    (grant_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*DW-1:0] slice(input int i, input logic [DW-1:0] v);
        logic [4*DW-1:0] r;
        r = '0;
        r[i*DW +: DW] = v;
        return r;
    endfunction

    // Model of one clock edge, from the currently driven inputs.
    function automatic void model_edge();
        int pi;
        logic [DW-1:0] d;
        pi = -1;
        exp_valid = 1'b0;
        if (reset) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_ov   = '0;
            m_gerr = 1'b0;
            return;
        end
        if (enable) begin
            if ($countones(grant_vector) > 1) begin
                m_gerr = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (grant_vector[i]) begin
                        if (mq[i].size() == 0) m_gerr = 1'b1;
                        else pi = i;
                    end
                end
            end
        end
        if (pi >= 0) begin
            d = mq[pi].pop_front();
            exp_q.push_back({2'(pi), d});
            exp_valid = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(push_data[i*DW +: DW]);
                else m_ov[i] = 1'b1;
            end
        end
    endfunction

    // driver
    task automatic step(input logic rst, input logic en, input logic [3:0] p,
                        input logic [4*DW-1:0] pd, input logic [3:0] g);
        reset        = rst;
        enable       = en;
        push         = p;
        push_data    = pd;
        grant_vector = g;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            logic [W-1:0] e;
            logic [3:0] m_req, m_full;
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (out_valid) begin
                    check("out_id", 32'(out_id), 32'(e[W-1:DW]));
                    check("out_data", 32'(out_data), 32'(e[DW-1:0]));
                end
            end
            for (int i = 0; i < 4; i++) begin
                m_req[i]  = (mq[i].size() != 0);
                m_full[i] = (mq[i].size() == DEPTH);
            end
            check("req_vector", 32'(req_vector), 32'(m_req));
            check("full", 32'(full), 32'(m_full));
            check("overflow", 32'(overflow), 32'(m_ov));
            check("grant_err", 32'(grant_err), 32'(m_gerr));
        end
    end

    initial begin
        logic [3:0] g;
        logic [3:0] p;
        int r;

        step(1'b1, 1'b0, 4'b0000, '0, 4'b0000);
        mon_en = 1'b1;
        @(negedge clk); #1;
        check("reset_out_id", 32'(out_id), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        step(1'b0, 1'b0, 4'b0000, '0, 4'b0000);

        // basic flow
        step(1'b0, 1'b0, 4'b0100, slice(2, 8'hA1), 4'b0000);
        step(1'b0, 1'b1, 4'b0000, '0, 4'b0100);
        step(1'b0, 1'b0, 4'b0000, '0, 4'b0000);
        check("basic_out_data", 32'(out_data), 32'hA1);

        // fill and overflow FIFO 0, then drain
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 4'b0001, slice(0, 8'(8'h10 + k)), 4'b0000);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'b0000, '0, 4'b0001);
        step(1'b0, 1'b0, 4'b0000, '0, 4'b0000);

        // full FIFO 1 with simultaneous push and pop
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 4'b0010, slice(1, 8'(8'h20 + k)), 4'b0000);
        step(1'b0, 1'b1, 4'b0010, slice(1, 8'h55), 4'b0010);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'b0000, '0, 4'b0010);
        step(1'b0, 1'b0, 4'b0000, '0, 4'b0000);
        check("fullpp_last", 32'(out_data), 32'h55);

        // pointer wrap on FIFO 3
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 4'b1000, slice(3, 8'(8'h30 + k)), 4'b0000);
            step(1'b0, 1'b1, 4'b0000, '0, 4'b1000);
        end

        // illegal grants
        step(1'b0, 1'b0, 4'b0011, slice(0, 8'h01) | slice(1, 8'h02), 4'b0000);
        step(1'b0, 1'b1, 4'b0000, '0, 4'b0011);
        step(1'b1, 1'b0, 4'b0000, '0, 4'b0000);
        step(1'b0, 1'b1, 4'b0000, '0, 4'b1000);
        step(1'b1, 1'b0, 4'b0000, '0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000, '0, 4'b1111);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) g = 4'(1 << $urandom_range(0, 3));
            else if (r == 7) g = 4'($urandom_range(0, 15));
            else g = 4'b0000;
            p = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0), p,
                 {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, g);
        end

        step(1'b0, 1'b0, 4'b0000, '0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000, '0, 4'b0000);
        @(negedge clk); #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
